// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-serial ALU sequencer.
// Covers ALU op codes, sequencer state encoding and small op-classification helpers.
package alu_seq_pkg;

    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 4;
    localparam int DATA_W    = BYTE_W * NUM_BYTES;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_RSH = 3'd1,
        OP_LSH = 3'd2,
        OP_DEC = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_CMP = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // RSH needs the upper neighbour's bit, and CMP must see the most significant difference first.
    function automatic logic msb_first(input alu_op_e op);
        return (op == OP_RSH) || (op == OP_CMP);
    endfunction

    // Ops whose c_out chains into the next byte and becomes the final cout.
    function automatic logic carry_op(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_LSH) || (op == OP_RSH);
    endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// 8-bit combinational ALU: one byte per call, carry/shift bit in and out.
// Also produces byte-compare flags.
module alu_seq_alu
    import alu_seq_pkg::*;
(
    input  alu_op_e           op,
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              c_in,
    output logic [BYTE_W-1:0] y,
    output logic              c_out,
    output logic              a_gt,
    output logic              a_eq
);

    logic [BYTE_W:0] sum;

    assign sum  = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, c_in};
    assign a_gt = (a > b);
    assign a_eq = (a == b);

    always_comb begin
        y     = '0;
        c_out = 1'b0;
        case (op)
            OP_ADD: begin
                y     = sum[BYTE_W-1:0];
                c_out = sum[BYTE_W];
            end
            OP_RSH: begin
                y     = {c_in, a[BYTE_W-1:1]};
                c_out = a[0];
            end
            OP_LSH: begin
                y     = {a[BYTE_W-2:0], c_in};
                c_out = a[BYTE_W-1];
            end
            OP_DEC: begin
                y     = a - 8'd1;
                c_out = (a == '0);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            // XOR doubles as the CMP data output: zero bytes mark equal positions.
            OP_XOR: y = a ^ b;
            OP_CMP: y = a ^ b;
            default: begin
                y     = '0;
                c_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Byte-serial sequencer around the 8-bit ALU.
// Processes 1..4 bytes of a/b per request, then presents a done pulse.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last completed result
// RUN   | one byte per cycle through the ALU, cnt_q counts down to 0
// DONE  | single-cycle completion, done=1
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [1:0]        nbm1,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              a_larger,
    output logic              equal,
    output logic              zero
);

    seq_state_e        state, state_nxt;
    alu_op_e           op_q;
    logic [1:0]        nbm1_q;
    logic [1:0]        cnt_q;
    logic [1:0]        pos;
    logic [DATA_W-1:0] a_q, b_q;
    logic [DATA_W-1:0] acc_q, acc_nxt;
    logic              carry_q;
    logic              cmp_dec_q, cmp_gt_q;
    logic              cmp_dec_nxt, cmp_gt_nxt;
    logic              accept, dec_bad, last;

    logic [BYTE_W-1:0] alu_a, alu_b, alu_y;
    logic              alu_cin, alu_cout, alu_gt, alu_eq;

    assign accept  = (state == ST_IDLE) && start;
    assign dec_bad = (alu_op_e'(op) == OP_DEC) && (nbm1 != 2'd0);
    assign last    = (cnt_q == 2'd0);

    // cnt_q counts down, so MSB-first ops use it directly as the byte position.
    assign pos     = msb_first(op_q) ? cnt_q : (nbm1_q - cnt_q);
    assign alu_a   = a_q[{pos, 3'b000} +: BYTE_W];
    assign alu_b   = b_q[{pos, 3'b000} +: BYTE_W];
    assign alu_cin = carry_op(op_q) ? carry_q : 1'b0;

    assign cmp_dec_nxt = cmp_dec_q | ~alu_eq;
    assign cmp_gt_nxt  = cmp_dec_q ? cmp_gt_q : alu_gt;

    alu_seq_alu u_alu (
        .op    (op_q),
        .a     (alu_a),
        .b     (alu_b),
        .c_in  (alu_cin),
        .y     (alu_y),
        .c_out (alu_cout),
        .a_gt  (alu_gt),
        .a_eq  (alu_eq)
    );

    always_comb begin
        acc_nxt = acc_q;
        acc_nxt[{pos, 3'b000} +: BYTE_W] = alu_y;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = dec_bad ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= OP_ADD;
            nbm1_q    <= '0;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            cmp_dec_q <= 1'b0;
            cmp_gt_q  <= 1'b0;
            err       <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            a_larger  <= 1'b0;
            equal     <= 1'b0;
            zero      <= 1'b0;
        end else if (accept) begin
            op_q      <= alu_op_e'(op);
            nbm1_q    <= nbm1;
            cnt_q     <= nbm1;
            a_q       <= a;
            b_q       <= b;
            acc_q     <= '0;
            carry_q   <= cin;
            cmp_dec_q <= 1'b0;
            cmp_gt_q  <= 1'b0;
            // A rejected DEC only flags err; the previous result and flags stay visible.
            err       <= dec_bad;
        end else if (state == ST_RUN) begin
            cnt_q     <= cnt_q - 2'd1;
            carry_q   <= alu_cout;
            acc_q     <= acc_nxt;
            cmp_dec_q <= cmp_dec_nxt;
            cmp_gt_q  <= cmp_gt_nxt;
            if (last) begin
                result   <= acc_nxt;
                cout     <= carry_op(op_q) ? alu_cout : 1'b0;
                a_larger <= (op_q == OP_CMP) && cmp_gt_nxt;
                equal    <= (op_q == OP_CMP) && !cmp_dec_nxt;
                zero     <= (acc_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues expected completions,
// the monitor compares them whenever done is seen.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [1:0]  nbm1;
    logic [31:0] a, b;
    logic        cin;
    logic        busy, done, err, cout, a_larger, equal, zero;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string       name;
        logic [31:0] result;
        logic        cout;
        logic        a_larger;
        logic        equal;
        logic        zero;
        logic        err;
        int          lat;
        int          start_edge;
    } exp_t;

    exp_t sb[$];

    alu_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .nbm1     (nbm1),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .result   (result),
        .cout     (cout),
        .a_larger (a_larger),
        .equal    (equal),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending op", cyc);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_result"},   result,             e.result);
                chk({e.name, "_cout"},     {31'd0, cout},     {31'd0, e.cout});
                chk({e.name, "_a_larger"}, {31'd0, a_larger}, {31'd0, e.a_larger});
                chk({e.name, "_equal"},    {31'd0, equal},    {31'd0, e.equal});
                chk({e.name, "_zero"},     {31'd0, zero},     {31'd0, e.zero});
                chk({e.name, "_err"},      {31'd0, err},      {31'd0, e.err});
                chk({e.name, "_latency"},  32'(cyc - e.start_edge + 1), 32'(e.lat));
            end
        end
    end

    task automatic launch(input string name, input logic [2:0] o, input logic [1:0] n,
                          input logic [31:0] aa, input logic [31:0] bb, input logic ci,
                          input logic [31:0] er, input logic ec, input logic eg,
                          input logic eq, input logic ez, input logic ee,
                          input int el, input bit push);
        exp_t e;
        @(negedge clk);
        op    = o;
        nbm1  = n;
        a     = aa;
        b     = bb;
        cin   = ci;
        start = 1'b1;
        if (push) begin
            e.name       = name;
            e.result     = er;
            e.cout       = ec;
            e.a_larger   = eg;
            e.equal      = eq;
            e.zero       = ez;
            e.err        = ee;
            e.lat        = el;
            e.start_edge = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got busy=1 after 12 cycles expected busy=0", name);
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [1:0] n,
                       input logic [31:0] aa, input logic [31:0] bb, input logic ci,
                       input logic [31:0] er, input logic ec, input logic eg,
                       input logic eq, input logic ez, input logic ee, input int el);
        launch(name, o, n, aa, bb, ci, er, ec, eg, eq, ez, ee, el, 1'b1);
        wait_idle(name);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = '0;
        nbm1    = '0;
        a       = '0;
        b       = '0;
        cin     = 1'b0;
        #1;
        chk("rst_busy",   {31'd0, busy},     32'd0);
        chk("rst_done",   {31'd0, done},     32'd0);
        chk("rst_err",    {31'd0, err},      32'd0);
        chk("rst_result", result,            32'd0);
        chk("rst_flags",  {28'd0, cout, a_larger, equal, zero}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        //  name        op      nbm1 a             b             cin  result        cout lg eq z  err lat
        run("add2",     OP_ADD, 2'd1, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run("dec_bad",  OP_DEC, 2'd2, 32'h0000_0055, 32'h0,        1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1);
        run("add4",     OP_ADD, 2'd3, 32'hFFFF_FFFF, 32'h0,        1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5);
        run("rsh2",     OP_RSH, 2'd1, 32'h0000_0181, 32'h0,        1'b0, 32'h0000_00C0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run("lsh2",     OP_LSH, 2'd1, 32'h0000_8081, 32'h0,        1'b0, 32'h0000_0102, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run("cmp_gt",   OP_CMP, 2'd1, 32'h0000_0155, 32'h0000_00AA, 1'b0, 32'h0000_01FF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        run("cmp_eq",   OP_CMP, 2'd1, 32'h0000_1234, 32'h0000_1234, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        run("cmp_lt",   OP_CMP, 2'd3, 32'h1234_FF00, 32'h1235_0000, 1'b0, 32'h0001_FF00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5);
        run("and1",     OP_AND, 2'd0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        run("xor3",     OP_XOR, 2'd2, 32'h00FF_00FF, 32'h0F0F_0F0F, 1'b0, 32'h00F0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        run("or2",      OP_OR,  2'd1, 32'h0000_1200, 32'h0000_0034, 1'b0, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run("dec1",     OP_DEC, 2'd0, 32'h0000_0000, 32'h0,        1'b0, 32'h0000_00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
        run("add3_cin", OP_ADD, 2'd2, 32'h0000_FFFF, 32'h0,        1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);

        // A second start inside RUN must not queue a second operation.
        launch("midstart", OP_ADD, 2'd3, 32'h1, 32'h2, 1'b0, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1);
        @(negedge clk);
        op    = OP_XOR;
        a     = 32'hDEAD_BEEF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("midstart");

        // Reset in the middle of RUN discards the operation.
        launch("rst_mid", OP_ADD, 2'd3, 32'h10, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rstmid_busy",   {31'd0, busy}, 32'd0);
        chk("rstmid_done",   {31'd0, done}, 32'd0);
        chk("rstmid_result", result,        32'd0);
        chk("rstmid_flags",  {27'd0, err, cout, a_larger, equal, zero}, 32'd0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Start on the first edge after reset release is accepted.
        run("post_rst", OP_ADD, 2'd0, 32'h5, 32'h6, 1'b0, 32'h0000_000B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have ports: clk input 1 (system clock, rising edge); reset_n input 1 (asynchronous, active-low reset).
REQ-002 SHALL have ports: start input 1 (request strobe); op input 3 (ALU op code: ADD=0, RSH=1, LSH=2, DEC=3, AND=4, OR=5, XOR=6, CMP=7); nbm1 input 2 (byte count minus one, 0..3); a input 32; b input 32; cin input 1 (initial carry).
REQ-003 SHALL have ports: busy output 1; done output 1 (one-cycle completion pulse); err output 1 (valid with done); result output 32; cout output 1; a_larger output 1; equal output 1; zero output 1.
REQ-004 SHALL use one clock domain (clk) with asynchronous active-low reset reset_n.

Function
REQ-005 SHALL implement states IDLE, RUN and DONE, with transitions IDLE->RUN on start, RUN->DONE after the last byte, and DONE->IDLE unconditionally.
REQ-006 SHALL, when start=1 in IDLE, capture op, nbm1, a, b and cin at that edge; busy=1 from the next cycle until DONE exits.
REQ-007 SHALL ignore start in RUN and DONE; no queuing.
REQ-008 SHALL make RUN last exactly N=nbm1+1 cycles, passing one byte through the 8-bit ALU per cycle; done=1 for exactly the single DONE cycle, which is N+1 cycles after the start edge.
REQ-009 SHALL use byte order LSB-first for ADD, LSH, AND, OR, XOR and DEC, and MSB-first for RSH and CMP.
REQ-010 SHALL feed cin to the first byte's c_in and the previous byte's c_out to each later byte's c_in: carry for ADD, shifted-out bit for LSH (into bit0) and RSH (into bit7); c_in=0 for logic ops.
REQ-011 SHALL set cout from the last processed byte's c_out for ADD, LSH and RSH, and to 0 for all other ops.
REQ-012 SHALL process CMP MSB-first: a_larger and equal are latched at the first unequal byte; equal=1 and a_larger=0 if all bytes match; both are 0 for non-CMP ops; result carries the per-byte ALU output.
REQ-013 SHALL compute zero=1 iff all N result bytes are 0.
REQ-014 SHALL force result bytes above N-1 to 0.
REQ-015 SHALL treat DEC with nbm1!=0 as an error: no ALU passes, RUN skipped (IDLE->DONE), done=1 with err=1, result, flags and cout unchanged; done occurs 1 cycle after the start edge.
REQ-016 SHALL hold result, cout, a_larger, equal, zero and err stable from DONE until the next accepted start.

Reset
REQ-017 SHALL, while reset_n=0 (including mid-RUN), force state=IDLE, busy=0, done=0, err=0, result=0, cout=0, a_larger=0, equal=0, zero=0 immediately; the operation in flight is discarded.
REQ-018 SHALL ignore start sampled in the first edge after reset_n deasserts only if reset_n was low at that edge; otherwise start is accepted normally.

Structure
REQ-019 SHALL place ALU op-code constants and state encodings in the shared package used by the processor.
REQ-020 SHALL instantiate the existing alu as its single sub-module; the sequencer holds the byte index, carry register, CMP-decided flag and result shift register.

Verification
REQ-021 SHALL verify ADD with nbm1=1, a=0x000000FF, b=0x00000001, cin=0: result=0x00000100, cout=0, zero=0, and done 3 cycles after start.
REQ-022 SHALL verify ADD with nbm1=3, a=0xFFFFFFFF, b=0, cin=1: result=0, cout=1, zero=1, and done 5 cycles after start.
REQ-023 SHALL verify RSH with nbm1=1, a=0x0181, cin=0: result=0x00C0, cout=1; and LSH with nbm1=1, a=0x8081, cin=0: result=0x0102, cout=1.
REQ-024 SHALL verify CMP with nbm1=1, a=0x0155, b=0x00AA: a_larger=1, equal=0, result=0x01FF; and with a=b=0x1234: equal=1, zero=1.
REQ-025 SHALL verify that start pulsed mid-RUN is ignored (single done), and that reset_n low mid-RUN clears busy and result with no done.
REQ-026 SHALL verify DEC with nbm1=2: done and err asserted 1 cycle after start, with result unchanged.
